// File: rtl/alu_arbiter_if.sv
// Bundle between two ALU requesters, the arbiter and the shared combinational ALU.
// The slave modport is the arbiter's view. The master modport is the environment's
// view: requesters plus the ALU.
interface alu_arbiter_if;
   logic        req0;
   logic        req1;
   logic [3:0]  op0;
   logic [3:0]  op1;
   logic [15:0] a0;
   logic [15:0] a1;
   logic [15:0] b0;
   logic [15:0] b1;
   logic        ack0;
   logic        ack1;
   logic [15:0] res0;
   logic [15:0] res1;
   logic [3:0]  szcv0;
   logic [3:0]  szcv1;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_op;
   logic [15:0] alu_res;
   logic [3:0]  alu_szcv;
   logic        busy;
   logic        gnt;

   modport slave (
      input  req0, req1, op0, op1, a0, a1, b0, b1, alu_res, alu_szcv,
      output ack0, ack1, res0, res1, szcv0, szcv1, alu_a, alu_b, alu_op, busy, gnt
   );

   modport master (
      output req0, req1, op0, op1, a0, a1, b0, b1, alu_res, alu_szcv,
      input  ack0, ack1, res0, res1, szcv0, szcv1, alu_a, alu_b, alu_op, busy, gnt
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU.
// Each operation takes three cycles: IDLE, EXEC, RESP.
//
// state | meaning
// IDLE  | waiting; any req starts an operation and latches the winner's operands
// EXEC  | ALU inputs are stable; the result is captured at the end of this cycle
// RESP  | the winner's ack is high and its res/szcv are updated; reqs are ignored
module alu_arbiter #(
   parameter bit FAIR = 1'b1
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

   state_t      state_q;
   logic        gnt_q;
   logic        last_q;
   logic        busy_q;
   logic        ack0_q;
   logic        ack1_q;
   logic [15:0] res0_q;
   logic [15:0] res1_q;
   logic [3:0]  szcv0_q;
   logic [3:0]  szcv1_q;
   logic [15:0] alu_a_q;
   logic [15:0] alu_b_q;
   logic [3:0]  alu_op_q;
   logic        win_d;

   // Winner for an IDLE-cycle request. A lone request always wins.
   // On a tie, FAIR picks the port not served last; otherwise port 0 wins.
   always_comb begin
      win_d = 1'b0;
      if (FAIR) begin
         if (bus.req0 && bus.req1) win_d = ~last_q;
         else                      win_d = bus.req1 & ~bus.req0;
      end else begin
         win_d = ~bus.req0;
      end
   end

   // Sequencer with registered outputs. ack is a one-cycle pulse that covers the RESP cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         gnt_q    <= 1'b0;
         last_q   <= 1'b1;
         busy_q   <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         res0_q   <= 16'h0000;
         res1_q   <= 16'h0000;
         szcv0_q  <= 4'h0;
         szcv1_q  <= 4'h0;
         alu_a_q  <= 16'h0000;
         alu_b_q  <= 16'h0000;
         alu_op_q <= 4'h0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.req0 || bus.req1) begin
                  state_q  <= ST_EXEC;
                  busy_q   <= 1'b1;
                  gnt_q    <= win_d;
                  alu_op_q <= win_d ? bus.op1 : bus.op0;
                  alu_a_q  <= win_d ? bus.a1  : bus.a0;
                  alu_b_q  <= win_d ? bus.b1  : bus.b0;
               end
            end
            ST_EXEC: begin
               state_q <= ST_RESP;
               last_q  <= gnt_q;
               if (gnt_q) begin
                  res1_q  <= bus.alu_res;
                  szcv1_q <= bus.alu_szcv;
                  ack1_q  <= 1'b1;
               end else begin
                  res0_q  <= bus.alu_res;
                  szcv0_q <= bus.alu_szcv;
                  ack0_q  <= 1'b1;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ack0   = ack0_q;
   assign bus.ack1   = ack1_q;
   assign bus.res0   = res0_q;
   assign bus.res1   = res1_q;
   assign bus.szcv0  = szcv0_q;
   assign bus.szcv1  = szcv1_q;
   assign bus.alu_a  = alu_a_q;
   assign bus.alu_b  = alu_b_q;
   assign bus.alu_op = alu_op_q;
   assign bus.busy   = busy_q;
   assign bus.gnt    = gnt_q;

endmodule
